delay_line_arbiter: RTL

//  Shares one fixed-latency delay pipeline among NUM_REQ requesters. Round-robin arbiter

---
 rtl/delay_arb_pkg.sv | 30 +++
 rtl/delay_line_arbiter_rr_pick.sv | 41 ++++
 rtl/delay_line_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/delay_arb_pkg.sv
// Shared definitions for the delay-line arbiter: default parameters and
// width helpers used by the arbiter top and its round-robin picker.
package delay_arb_pkg;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_BIT_WIDTH       = 8;
    localparam int DEF_LATENCY         = 2;
    localparam int DEF_MAX_OUTSTANDING = 2;

    // Requester id width; at least one bit even for degenerate sizes.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Outstanding-counter width: must hold 0..max inclusive.
    function automatic int cnt_w(input int max_out);
        return (max_out > 0) ? $clog2(max_out + 1) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

    // Pipeline stage record at the default sizing. The top declares its own
    // copy of this layout because its field widths follow instance parameters.
    typedef struct packed {
        logic                     v;
        logic [DEF_ID_W-1:0]      id;
        logic [DEF_BIT_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/delay_line_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr (wrapping),
// returned both one-hot and as an index. Purely combinational.
module rr_pick
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    // Doubling the vector turns the wrap-around search into a plain
    // lowest-set-bit search over the rotated copy.
    logic [2*NUM_REQ-1:0] dbl;
    logic [ID_W:0]        sum;

    assign dbl = {eligible, eligible} >> ptr;

    // Priority-encode the rotated vector and map the offset back to an id.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && dbl[k]) begin
                grant_any = 1'b1;
                sum       = {1'b0, ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_REQ))
                    sum = sum - (ID_W+1)'(NUM_REQ);
                grant_id  = sum[ID_W-1:0];
            end
        end
        grant[grant_id] = grant_any;
    end

endmodule

// File: rtl/delay_line_arbiter.sv
// Shares one fixed-latency delay pipeline among NUM_REQ requesters. A
// round-robin grant admits at most one word per cycle, tagged with its owner;
// the word reappears on rsp_* exactly LATENCY cycles after acceptance.
// Per-requester counters cap the number of words each owner has in flight.
module delay_line_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
    parameter int LATENCY         = DEF_LATENCY,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush,
    output logic                          rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]      rsp_id,
    output logic [BIT_WIDTH-1:0]          rsp_data,
    output logic                          busy
);

    localparam int               ID_W    = id_w(NUM_REQ);
    localparam int               CNT_W   = cnt_w(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    typedef struct packed {
        logic                 v;
        logic [ID_W-1:0]      id;
        logic [BIT_WIDTH-1:0] data;
    } stage_t;

    logic [NUM_REQ-1:0][BIT_WIDTH-1:0] words;
    logic [NUM_REQ-1:0]                eligible;
    logic [NUM_REQ-1:0]                grant;
    logic [ID_W-1:0]                   grant_id;
    logic                              grant_any;
    logic [ID_W-1:0]                   rr_ptr;
    logic [CNT_W-1:0]                  out_cnt [NUM_REQ];
    stage_t                            stg     [LATENCY];
    stage_t                            stg_in;
    logic [LATENCY-1:0]                stg_v;

    assign words = req_data;

    // Gating with rst keeps req_ready low while reset is held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign eligible[i] = rst & req_valid[i] & ~flush & (out_cnt[i] < CNT_MAX);
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    // Record entering the pipeline; zero when nothing is accepted.
    always_comb begin
        stg_in.v    = grant_any;
        stg_in.id   = grant_any ? grant_id        : '0;
        stg_in.data = grant_any ? words[grant_id] : '0;
    end

    // Pointer moves just past the winner; holds on idle and flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end

    // The last stage doubles as the response register, so LATENCY registers
    // separate the accept edge from the response cycle.
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        if (s == 0) begin : g_first
            // Load the accepted word; flush drops everything in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       stg[0] <= '0;
                else if (flush) stg[0] <= '0;
                else            stg[0] <= stg_in;
            end
        end else begin : g_next
            // Shift one stage; flush drops everything in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)       stg[s] <= '0;
                else if (flush) stg[s] <= '0;
                else            stg[s] <= stg[s-1];
            end
        end
        assign stg_v[s] = stg[s].v;
    end

    assign rsp_valid = stg[LATENCY-1].v;
    assign rsp_id    = stg[LATENCY-1].id;
    assign rsp_data  = stg[LATENCY-1].v ? stg[LATENCY-1].data : '0;
    assign busy      = |stg_v;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = grant[i];
        assign dec = rsp_valid & (rsp_id == ID_W'(i));

        // Track words in flight for requester i; accept and return together cancel.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                out_cnt[i] <= '0;
            else if (flush)
                out_cnt[i] <= '0;
            else if (inc && !dec)
                out_cnt[i] <= out_cnt[i] + 1'b1;
            else if (dec && !inc)
                out_cnt[i] <= out_cnt[i] - 1'b1;
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
            !(inc && !dec && out_cnt[i] == CNT_MAX));
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
            !(dec && !inc && out_cnt[i] == '0));
    end

endmodule
